// File: rtl/console_writer.sv
// console_writer: write-side controller for an 80x30 console text buffer.
// Consumes a byte stream over valid/ready, tracks a cursor, places printable
// characters, interprets LF/CR/BS/FF, scrolls by copying the buffer up one
// row, and clears the screen. Every output is driven straight from a flop.
module console_writer #(
    parameter int unsigned COLS  = 80,
    parameter int unsigned ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        busy,
    output logic [11:0] text_addr,
    output logic        text_write,
    output logic [7:0]  text_in,
    input  logic [7:0]  text_out,
    output logic [4:0]  cursor_row,
    output logic [6:0]  cursor_col
);

    // Screen geometry in the 12-bit address domain.
    localparam logic [11:0] ROW_SPAN   = 12'(COLS);
    localparam logic [11:0] LAST_ADDR  = 12'(COLS * ROWS - 1);
    localparam logic [11:0] FILL_START = 12'(COLS * (ROWS - 1));
    localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
    localparam logic [6:0]  LAST_COL   = 7'(COLS - 1);

    // Control codes interpreted in IDLE.
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_PUT,
        S_SCROLL_RD,
        S_SCROLL_WR,
        S_SCROLL_FILL
    } state_t;

    // Linear cell address of (row, col).
    function automatic logic [11:0] cell_addr(input logic [4:0] row,
                                              input logic [6:0] col);
        return (12'(row) * ROW_SPAN) + 12'(col);
    endfunction

    state_t      state_q, state_d;
    // idx is the next address to blank in CLEAR/SCROLL_FILL, and the scroll
    // source address in SCROLL_RD/SCROLL_WR; the two uses never overlap.
    logic [11:0] idx_q, idx_d;
    logic        put_bs_q, put_bs_d;
    logic [4:0]  row_q, row_d;
    logic [6:0]  col_q, col_d;
    logic [11:0] text_addr_q, text_addr_d;
    logic        text_write_q, text_write_d;
    logic [7:0]  text_in_q, text_in_d;
    logic        char_ready_q, char_ready_d;
    logic        busy_q, busy_d;

    logic        accept;
    logic        printable;

    assign accept    = char_ready_q && char_valid;
    assign printable = (char_data >= 8'h20) && (char_data <= 8'h7E);

    // Next-state, next-cursor and next-output computation for every state.
    always_comb begin
        // NOTE: every *_d is given a default before the case so that no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d      = state_q;
        idx_d        = idx_q;
        put_bs_d     = put_bs_q;
        row_d        = row_q;
        col_d        = col_q;
        text_addr_d  = text_addr_q;
        text_write_d = 1'b0;
        text_in_d    = text_in_q;

        unique case (state_q)
            // Blank one cell per cycle from idx up to the end of the screen.
            S_CLEAR, S_SCROLL_FILL: begin
                if (idx_q <= LAST_ADDR) begin
                    text_addr_d  = idx_q;
                    text_write_d = 1'b1;
                    text_in_d    = BLANK;
                    idx_d        = idx_q + 12'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if (accept) begin
                    if (printable) begin
                        // The write goes out in the very next cycle (PUT).
                        state_d      = S_PUT;
                        put_bs_d     = 1'b0;
                        text_addr_d  = cell_addr(row_q, col_q);
                        text_write_d = 1'b1;
                        text_in_d    = char_data;
                    end else begin
                        case (char_data)
                            CH_LF: begin
                                col_d = '0;
                                if (row_q < LAST_ROW) begin
                                    row_d = row_q + 5'd1;
                                end else begin
                                    state_d     = S_SCROLL_RD;
                                    idx_d       = ROW_SPAN;
                                    text_addr_d = ROW_SPAN;
                                end
                            end
                            CH_CR: begin
                                col_d = '0;
                            end
                            CH_BS: begin
                                // Backspace at column 0 is ignored.
                                if (col_q != '0) begin
                                    col_d        = col_q - 7'd1;
                                    state_d      = S_PUT;
                                    put_bs_d     = 1'b1;
                                    text_addr_d  = cell_addr(row_q, col_q - 7'd1);
                                    text_write_d = 1'b1;
                                    text_in_d    = BLANK;
                                end
                            end
                            CH_FF: begin
                                // Cell 0 is written right away so the clear
                                // occupies exactly one cycle per cell.
                                row_d        = '0;
                                col_d        = '0;
                                state_d      = S_CLEAR;
                                text_addr_d  = '0;
                                text_write_d = 1'b1;
                                text_in_d    = BLANK;
                                idx_d        = 12'd1;
                            end
                            default: begin
                                // Unrecognised byte: consumed, no effect.
                            end
                        endcase
                    end
                end
            end

            // The write is on the bus this cycle; now advance the cursor.
            S_PUT: begin
                state_d = S_IDLE;
                if (!put_bs_q) begin
                    if (col_q < LAST_COL) begin
                        col_d = col_q + 7'd1;
                    end else begin
                        col_d = '0;
                        if (row_q < LAST_ROW) begin
                            row_d = row_q + 5'd1;
                        end else begin
                            state_d     = S_SCROLL_RD;
                            idx_d       = ROW_SPAN;
                            text_addr_d = ROW_SPAN;
                        end
                    end
                end
            end

            // text_addr already points at src; the read data is copied one
            // row up on the following cycle.
            S_SCROLL_RD: begin
                state_d      = S_SCROLL_WR;
                text_addr_d  = idx_q - ROW_SPAN;
                text_write_d = 1'b1;
                text_in_d    = text_out;
            end

            S_SCROLL_WR: begin
                if (idx_q == LAST_ADDR) begin
                    state_d      = S_SCROLL_FILL;
                    text_addr_d  = FILL_START;
                    text_write_d = 1'b1;
                    text_in_d    = BLANK;
                    idx_d        = FILL_START + 12'd1;
                end else begin
                    state_d     = S_SCROLL_RD;
                    idx_d       = idx_q + 12'd1;
                    text_addr_d = idx_q + 12'd1;
                end
            end

            default: begin
                state_d = S_CLEAR;
                idx_d   = '0;
            end
        endcase

        // Ready and busy always describe the state being entered.
        char_ready_d = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
    end

    // State, cursor and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q      <= S_CLEAR;
            idx_q        <= '0;
            put_bs_q     <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            text_addr_q  <= '0;
            text_write_q <= 1'b0;
            text_in_q    <= BLANK;
            char_ready_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            put_bs_q     <= put_bs_d;
            row_q        <= row_d;
            col_q        <= col_d;
            text_addr_q  <= text_addr_d;
            text_write_q <= text_write_d;
            text_in_q    <= text_in_d;
            char_ready_q <= char_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign char_ready = char_ready_q;
    assign busy       = busy_q;
    assign text_addr  = text_addr_q;
    assign text_write = text_write_q;
    assign text_in    = text_in_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;

endmodule

// File: tb/tb_console_writer.sv
// tb_console_writer: directed bench for console_writer with a behavioural
// text buffer (combinational read, clocked write).
module tb_console_writer;

    localparam int CELLS = 2400;

    logic        clock      = 1'b0;
    logic        reset      = 1'b1;
    logic        char_valid = 1'b0;
    logic [7:0]  char_data  = 8'h00;
    logic        char_ready;
    logic        busy;
    logic [11:0] text_addr;
    logic        text_write;
    logic [7:0]  text_in;
    logic [7:0]  text_out;
    logic [4:0]  cursor_row;
    logic [6:0]  cursor_col;

    logic [7:0]  mem [CELLS];
    logic [7:0]  preload_img [CELLS];
    logic        preload_req = 1'b0;

    int n_checks  = 0;
    int n_errors  = 0;
    int wr_count  = 0;
    int c43_count = 0;
    int bad_addr  = 0;
    int timeouts  = 0;

    console_writer dut (
        .clock      (clock),
        .reset      (reset),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .busy       (busy),
        .text_addr  (text_addr),
        .text_write (text_write),
        .text_in    (text_in),
        .text_out   (text_out),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    always #5 clock = ~clock;

    assign text_out = (text_addr < 12'd2400) ? mem[text_addr] : 8'h00;

    // Buffer model plus write monitor; preload is a backdoor image load.
    always @(posedge clock) begin
        if (preload_req) begin
            for (int i = 0; i < CELLS; i++) mem[i] <= preload_img[i];
        end else if (text_write) begin
            wr_count <= wr_count + 1;
            if (text_in == 8'h43) c43_count <= c43_count + 1;
            if (text_addr < 12'd2400) mem[text_addr] <= text_in;
            else bad_addr <= bad_addr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a byte until accepted; returns in the cycle after the accept edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        char_data  = b;
        char_valid = 1'b1;
        while (!char_ready && n < 10000) begin
            tick();
            n++;
        end
        if (!char_ready) timeouts++;
        tick();
        char_valid = 1'b0;
    endtask

    // Count cycles until busy drops.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy && cycles < 10000) begin
            tick();
            cycles++;
        end
        if (busy) timeouts++;
    endtask

    initial begin
        int seq_err;
        int k;
        int w0;
        int c0;
        int cyc;
        logic [7:0] exp_b;

        // ---- reset and power-up clear ----
        reset = 1'b1;
        tick();
        check("rst_write", text_write, 0);
        check("rst_ready", char_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_addr", text_addr, 0);
        check("rst_text_in", text_in, 8'h20);
        check("rst_row", cursor_row, 0);
        check("rst_col", cursor_col, 0);
        reset = 1'b0;
        tick();
        seq_err = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (text_write !== 1'b1 || text_addr !== 12'(i) || text_in !== 8'h20 ||
                char_ready !== 1'b0 || busy !== 1'b1) seq_err++;
            tick();
        end
        check("clear_seq", seq_err, 0);
        check("clear_ready", char_ready, 1);
        check("clear_idle_write", text_write, 0);
        check("clear_row", cursor_row, 0);
        check("clear_col", cursor_col, 0);

        // ---- single printable at (0,0) ----
        send_byte(8'h41);
        check("put_a_write", text_write, 1);
        check("put_a_addr", text_addr, 0);
        check("put_a_data", text_in, 8'h41);
        check("put_a_ready_low", char_ready, 0);
        tick();
        check("put_a_ready_back", char_ready, 1);
        check("put_a_single", text_write, 0);
        check("put_a_row", cursor_row, 0);
        check("put_a_col", cursor_col, 1);

        // ---- end-of-line wrap at (5,79), then CR and BS at col 0 ----
        for (int i = 0; i < 5; i++) send_byte(8'h0A);
        for (int i = 0; i < 79; i++) send_byte(8'h2E);
        tick();
        check("pos_row", cursor_row, 5);
        check("pos_col", cursor_col, 79);
        send_byte(8'h42);
        check("wrap_addr", text_addr, 479);
        check("wrap_data", text_in, 8'h42);
        tick();
        check("wrap_row", cursor_row, 6);
        check("wrap_col", cursor_col, 0);
        w0 = wr_count;
        send_byte(8'h0D);
        send_byte(8'h08);
        tick();
        tick();
        check("cr_bs_no_write", wr_count - w0, 0);
        check("cr_bs_row", cursor_row, 6);
        check("cr_bs_col", cursor_col, 0);

        // ---- backspace mid-row: blank written at col-1, cursor stays ----
        send_byte(8'h2E);
        send_byte(8'h2E);
        tick();
        send_byte(8'h08);
        check("bs_addr", text_addr, 481);
        check("bs_data", text_in, 8'h20);
        tick();
        check("bs_col", cursor_col, 1);

        // ---- scroll on LF at row 29 ----
        send_byte(8'h0C);
        wait_idle(cyc);
        for (int i = 0; i < 29; i++) send_byte(8'h0A);
        for (int i = 0; i < 3; i++) send_byte(8'h39);
        tick();
        check("pre_scroll_row", cursor_row, 29);
        check("pre_scroll_col", cursor_col, 3);
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 80; c++) begin
                if (r == 0) exp_b = 8'h30;
                else if (r == 1) exp_b = 8'h31;
                else if (r == 29) exp_b = 8'h39;
                else exp_b = 8'h61 + 8'((r * 7 + c) % 26);
                preload_img[r * 80 + c] = exp_b;
            end
        end
        preload_req = 1'b1;
        tick();
        preload_req = 1'b0;
        send_byte(8'h0A);
        k = 0;
        seq_err = 0;
        while (busy && k < 10000) begin
            if (k < 4640) begin
                if (k % 2 == 0) begin
                    if (text_write !== 1'b0 || text_addr !== 12'(80 + k / 2)) seq_err++;
                end else begin
                    if (text_write !== 1'b1 || text_addr !== 12'(k / 2) ||
                        text_in !== preload_img[80 + k / 2]) seq_err++;
                end
            end else begin
                if (text_write !== 1'b1 || text_addr !== 12'(2320 + k - 4640) ||
                    text_in !== 8'h20) seq_err++;
            end
            k++;
            tick();
        end
        check("scroll_cycles", k, 4720);
        check("scroll_seq", seq_err, 0);
        seq_err = 0;
        for (int i = 0; i < CELLS; i++) begin
            exp_b = (i < 2320) ? preload_img[i + 80] : 8'h20;
            if (mem[i] !== exp_b) seq_err++;
        end
        check("scroll_image", seq_err, 0);
        check("scroll_row0", mem[0], 8'h31);
        check("scroll_row28", mem[28 * 80 + 5], 8'h39);
        check("scroll_row29", mem[2399], 8'h20);
        check("scroll_cur_row", cursor_row, 29);
        check("scroll_cur_col", cursor_col, 0);
        check("scroll_ready", char_ready, 1);

        // ---- byte held during a scroll is consumed only once, at IDLE ----
        send_byte(8'h0A);
        char_data  = 8'h43;
        char_valid = 1'b1;
        c0 = c43_count;
        wait_idle(cyc);
        check("hold_scroll_cycles", cyc, 4720);
        check("hold_not_consumed", c43_count - c0, 0);
        check("hold_ready", char_ready, 1);
        tick();
        check("hold_put_write", text_write, 1);
        check("hold_put_addr", text_addr, 2320);
        check("hold_put_data", text_in, 8'h43);
        char_valid = 1'b0;
        tick();
        tick();
        check("hold_one_write", c43_count - c0, 1);
        check("hold_col", cursor_col, 1);

        // ---- form feed clears the screen ----
        send_byte(8'h0C);
        check("ff_first_write", text_write, 1);
        check("ff_first_addr", text_addr, 0);
        wait_idle(cyc);
        check("ff_cycles", cyc, 2400);
        check("ff_row", cursor_row, 0);
        check("ff_col", cursor_col, 0);
        seq_err = 0;
        for (int i = 0; i < CELLS; i++) if (mem[i] !== 8'h20) seq_err++;
        check("ff_image", seq_err, 0);

        // ---- reset in the middle of SCROLL_WR (src = 1000) ----
        for (int i = 0; i < 29; i++) send_byte(8'h0A);
        send_byte(8'h0A);
        for (int i = 0; i < 1841; i++) tick();
        check("mid_wr_write", text_write, 1);
        check("mid_wr_addr", text_addr, 920);
        reset      = 1'b1;
        char_valid = 1'b1;
        char_data  = 8'h41;
        tick();
        char_valid = 1'b0;
        check("mid_rst_write", text_write, 0);
        check("mid_rst_row", cursor_row, 0);
        check("mid_rst_col", cursor_col, 0);
        check("mid_rst_busy", busy, 1);
        reset = 1'b0;
        tick();
        check("mid_clear_write", text_write, 1);
        check("mid_clear_addr", text_addr, 0);
        wait_idle(cyc);
        check("mid_clear_cycles", cyc, 2400);
        check("mid_ready", char_ready, 1);

        check("timeouts", timeouts, 0);
        check("bad_addr_writes", bad_addr, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
